detect_run_monitor: RTL and testbench
=====================================

Name: detect_run_monitor

Overview:
- Downstream consumer of the serial "111" run detector; samples its Mealy `detected` output every clock.
- Groups contiguous high cycles of `detected` into runs and measures each run's length (saturating).
- Hands each completed run length to a host through a one-deep valid/ack report slot.
- Keeps a saturating count of qualifying runs plus a sticky overflow flag for reports that were dropped.

Parameters:
- LEN_W, 8: width of run-length measurement and `rpt_len`.
- CNT_W, 8: width of `event_cnt`.
- MIN_RUN, 1: minimum run length that is counted and reported; shorter runs are discarded silently. Legal range 1 .. 2^LEN_W-1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- detected  input  1  upstream detector output; treated as settled before each rising edge.
- clear  input  1  synchronous clear of `event_cnt` and `rpt_overflow`.
- rpt_ack  input  1  host accepts the report; meaningful only while `rpt_valid`=1.
- rpt_valid  output  1  report slot full.
- rpt_len  output  LEN_W  length of the reported run in cycles; held stable while `rpt_valid`=1.
- rpt_overflow  output  1  sticky: at least one qualifying run was dropped because the slot was full.
- event_cnt  output  CNT_W  number of qualifying runs completed; saturating.
- busy  output  1  high while a run is in progress (state RUN).

Behaviour:
- Reset (`reset_n`=0 at an edge):
  - Tracker state goes to IDLE and `len_cnt` to 0.
  - Every output goes to 0: `rpt_valid`, `rpt_len`, `rpt_overflow`, `event_cnt`, `busy`.
  - Reset overrides every other input, including mid-run; a partial run is discarded and is not reported.
- Run tracker, states IDLE and RUN:
  - IDLE, detected=1: go to RUN, `len_cnt`=1.
  - IDLE, detected=0: stay in IDLE.
  - RUN, detected=1: stay in RUN; `len_cnt` increments and saturates at 2^LEN_W-1 with no wrap.
  - RUN, detected=0: the run ends; go to IDLE and set `len_cnt`=0. If `len_cnt` >= MIN_RUN, raise `post` (internal, this cycle only).
- `busy` is registered and equals (state==RUN).
- Latency: the report appears (`rpt_valid`=1) on the edge that samples the first detected=0 after the run. That is one cycle after the last detected=1 sample.
- Report slot, priority evaluated at each edge:
  - `pop` = rpt_valid & rpt_ack.
  - post & (!rpt_valid | pop): load `rpt_len` from `len_cnt` and set `rpt_valid`=1. A simultaneous pop and post gives a back-to-back report with `rpt_valid` staying 1.
  - pop & !post: `rpt_valid`=0; `rpt_len` keeps its old value.
  - post & rpt_valid & !pop: the new report is dropped, the slot is unchanged, and `rpt_overflow`=1.
  - `rpt_ack` while `rpt_valid`=0 is ignored.
- `event_cnt`:
  - Increments on every `post`, including dropped ones, and saturates at 2^CNT_W-1.
  - `clear`=1 forces `event_cnt`=0 and `rpt_overflow`=0 and has priority over a same-cycle post/drop. The post is still delivered to the slot if the slot accepts it.
  - `clear` does not affect the tracker or the report slot.
- Upstream relationship: an input stream of k>=3 consecutive ones produces a run of k-2 cycles. The block does not depend on this.

Decomposition:
- Shared package `fsm_pkg`:
  - Tracker state encoding: IDLE=1'b0, RUN=1'b1.
  - Default LEN_W and CNT_W constants.
- Sub-module `sat_counter`:
  - Parameter W; inputs clk, reset_n, clr, inc.
  - Output q; saturates at all-ones.
  - Instantiated twice, for `len_cnt` and `event_cnt`.
- The remaining logic (tracker FSM and report slot) stays in `detect_run_monitor`.

Test Plan:
- Reset: hold `reset_n`=0 for 2 cycles with detected=1. All outputs read 0; after release with detected=1, `busy`=1 one edge later.
- Single run: detected high for 3 cycles then low. `rpt_valid`=1 with `rpt_len`=3 on the first low-sample edge and `event_cnt`=1; pulse `rpt_ack` → `rpt_valid`=0 next edge.
- Overflow: two runs (len 2, then len 5) with no ack. `rpt_len` stays 2, `rpt_overflow`=1, `event_cnt`=2; assert `clear` → `event_cnt`=0, `rpt_overflow`=0, and `rpt_valid` is still 1 with len 2.
- Back-to-back: hold `rpt_ack`=1 on the edge where a second run (len 4) posts. `rpt_valid` stays 1, `rpt_len`=4, `rpt_overflow`=0.
- Saturation and MIN_RUN: with LEN_W=4, a run of 20 cycles gives `rpt_len`=15. With MIN_RUN=3, a run of 2 gives no report and `event_cnt` unchanged. With CNT_W=2, 5 runs give `event_cnt`=3.
- Mid-run reset: reset asserted in cycle 4 of a run gives no report, `event_cnt`=0, `busy`=0; a new run after release counts from 1.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the detect_run_monitor block: tracker state encoding
// and default widths.
package fsm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !(&r_q)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/detect_run_monitor.sv
// Measures runs of the upstream "111" detector output and reports each
// completed run length through a one-deep valid/ack slot.
module detect_run_monitor
    import fsm_pkg::*;
#(
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned MIN_RUN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             detected,
    input  logic             clear,
    input  logic             rpt_ack,
    output logic             rpt_valid,
    output logic [LEN_W-1:0] rpt_len,
    output logic             rpt_overflow,
    output logic [CNT_W-1:0] event_cnt,
    output logic             busy
);

    localparam logic [LEN_W-1:0] MinRunL = LEN_W'(MIN_RUN);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [LEN_W-1:0] w_len_cnt;
    logic [CNT_W-1:0] w_event_cnt;
    logic             w_post;
    logic             w_pop;
    logic             w_len_clr;
    logic             r_rpt_valid;
    logic [LEN_W-1:0] r_rpt_len;
    logic             r_rpt_overflow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_post      = 1'b0;
        case (r_state)
            IDLE: begin
                if (detected) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!detected) begin
                    w_state_nxt = IDLE;
                    w_post      = (w_len_cnt >= MinRunL);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // len_cnt is always 0 in IDLE, so incrementing on detected gives 1 on run start.
    assign w_len_clr = ~detected;

    sat_counter #(
        .W (LEN_W)
    ) u_len_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_len_clr),
        .inc     (detected),
        .q       (w_len_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_event_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (w_post),
        .q       (w_event_cnt)
    );

    assign w_pop = r_rpt_valid & rpt_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rpt_valid    <= 1'b0;
            r_rpt_len      <= '0;
            r_rpt_overflow <= 1'b0;
        end else begin
            if (w_post && (!r_rpt_valid || w_pop)) begin
                r_rpt_valid <= 1'b1;
                r_rpt_len   <= w_len_cnt;
            end else if (w_pop) begin
                r_rpt_valid <= 1'b0;
            end

            if (clear) begin
                r_rpt_overflow <= 1'b0;
            end else if (w_post && r_rpt_valid && !w_pop) begin
                r_rpt_overflow <= 1'b1;
            end
        end
    end

    assign rpt_valid    = r_rpt_valid;
    assign rpt_len      = r_rpt_len;
    assign rpt_overflow = r_rpt_overflow;
    assign event_cnt    = w_event_cnt;
    assign busy         = (r_state == RUN);

endmodule

// File: tb/tb_detect_run_monitor.sv
// Directed bench: a default-parameter instance driven from a vector table and a
// narrow instance (LEN_W=4, CNT_W=2, MIN_RUN=3) driven by hand sequences.
module tb_detect_run_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, detected, clear, rpt_ack;
    logic       rpt_valid, rpt_overflow, busy;
    logic [7:0] rpt_len, event_cnt;

    logic       s_reset_n, s_detected, s_clear, s_ack;
    logic       s_valid, s_ovf, s_busy;
    logic [3:0] s_len;
    logic [1:0] s_cnt;

    detect_run_monitor #(
        .LEN_W   (8),
        .CNT_W   (8),
        .MIN_RUN (1)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .detected     (detected),
        .clear        (clear),
        .rpt_ack      (rpt_ack),
        .rpt_valid    (rpt_valid),
        .rpt_len      (rpt_len),
        .rpt_overflow (rpt_overflow),
        .event_cnt    (event_cnt),
        .busy         (busy)
    );

    detect_run_monitor #(
        .LEN_W   (4),
        .CNT_W   (2),
        .MIN_RUN (3)
    ) u_dut_narrow (
        .clk          (clk),
        .reset_n      (s_reset_n),
        .detected     (s_detected),
        .clear        (s_clear),
        .rpt_ack      (s_ack),
        .rpt_valid    (s_valid),
        .rpt_len      (s_len),
        .rpt_overflow (s_ovf),
        .event_cnt    (s_cnt),
        .busy         (s_busy)
    );

    typedef struct {
        string      name;
        logic       rst_n, det, ack, clr;
        logic       ev;
        logic [7:0] el;
        logic       eo;
        logic [7:0] ec;
        logic       eb;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input string nm, input logic rst_n, input logic det, input logic ack,
                       input logic clr, input logic ev, input logic [7:0] el, input logic eo,
                       input logic [7:0] ec, input logic eb);
        vec_t v;
        v.name = nm; v.rst_n = rst_n; v.det = det; v.ack = ack; v.clr = clr;
        v.ev = ev; v.el = el; v.eo = eo; v.ec = ec; v.eb = eb;
        vecs.push_back(v);
    endtask

    // Applies inputs across one rising edge; outputs are then sampled at the negedge.
    task automatic cyc2(input logic rst_n, input logic det, input logic ack, input logic clr);
        s_reset_n = rst_n; s_detected = det; s_ack = ack; s_clear = clr;
        @(negedge clk);
    endtask

    task automatic check2(input string nm, input logic ev, input logic [3:0] el, input logic eo,
                          input logic [1:0] ec, input logic eb);
        n_checks++;
        if ({s_valid, s_len, s_ovf, s_cnt, s_busy} !== {ev, el, eo, ec, eb}) begin
            n_fail++;
            $display("FAIL %s: got valid=%b len=%0d ovf=%b cnt=%0d busy=%b, want valid=%b len=%0d ovf=%b cnt=%0d busy=%b",
                     nm, s_valid, s_len, s_ovf, s_cnt, s_busy, ev, el, eo, ec, eb);
        end
    endtask

    initial begin
        reset_n = 1'b0; detected = 1'b0; clear = 1'b0; rpt_ack = 1'b0;
        s_reset_n = 1'b0; s_detected = 1'b0; s_clear = 1'b0; s_ack = 1'b0;

        //   name            rst det ack clr  v  len  o  cnt busy
        add("rst_hold0",      0,  1,  0,  0,  0,  0,  0,  0,  0);
        add("rst_hold1",      0,  1,  0,  0,  0,  0,  0,  0,  0);
        add("rel_busy",       1,  1,  0,  0,  0,  0,  0,  0,  1);
        add("run1_c2",        1,  1,  0,  0,  0,  0,  0,  0,  1);
        add("run1_c3",        1,  1,  0,  0,  0,  0,  0,  0,  1);
        add("run1_post",      1,  0,  0,  0,  1,  3,  0,  1,  0);
        add("run1_ack_clr",   1,  0,  1,  1,  0,  3,  0,  0,  0);
        add("ovf_a_c1",       1,  1,  0,  0,  0,  3,  0,  0,  1);
        add("ovf_a_c2",       1,  1,  0,  0,  0,  3,  0,  0,  1);
        add("ovf_a_post",     1,  0,  0,  0,  1,  2,  0,  1,  0);
        for (int i = 0; i < 5; i++) add("ovf_b_run", 1, 1, 0, 0, 1, 2, 0, 1, 1);
        add("ovf_drop",       1,  0,  0,  0,  1,  2,  1,  2,  0);
        add("ovf_clear",      1,  0,  0,  1,  1,  2,  0,  0,  0);
        for (int i = 0; i < 4; i++) add("b2b_run", 1, 1, 0, 0, 1, 2, 0, 0, 1);
        add("b2b_post_pop",   1,  0,  1,  0,  1,  4,  0,  1,  0);
        add("b2b_pop",        1,  0,  1,  0,  0,  4,  0,  1,  0);
        add("ack_idle",       1,  0,  1,  0,  0,  4,  0,  1,  0);
        for (int i = 0; i < 2; i++) add("clrpost_run", 1, 1, 0, 0, 0, 4, 0, 1, 1);
        add("clr_with_post",  1,  0,  0,  1,  1,  2,  0,  0,  0);
        add("clr_post_ack",   1,  0,  1,  0,  0,  2,  0,  0,  0);
        for (int i = 0; i < 3; i++) add("mid_run", 1, 1, 0, 0, 0, 2, 0, 0, 1);
        add("mid_rst",        0,  1,  0,  0,  0,  0,  0,  0,  0);
        add("mid_rel",        1,  0,  0,  0,  0,  0,  0,  0,  0);
        add("new_run",        1,  1,  0,  0,  0,  0,  0,  0,  1);
        add("new_post",       1,  0,  0,  0,  1,  1,  0,  1,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n = vecs[i].rst_n; detected = vecs[i].det;
            rpt_ack = vecs[i].ack;   clear    = vecs[i].clr;
            @(negedge clk);
            n_checks++;
            if ({rpt_valid, rpt_len, rpt_overflow, event_cnt, busy} !==
                {vecs[i].ev, vecs[i].el, vecs[i].eo, vecs[i].ec, vecs[i].eb}) begin
                n_fail++;
                $display("FAIL %s[%0d]: got valid=%b len=%0d ovf=%b cnt=%0d busy=%b, want valid=%b len=%0d ovf=%b cnt=%0d busy=%b",
                         vecs[i].name, i, rpt_valid, rpt_len, rpt_overflow, event_cnt, busy,
                         vecs[i].ev, vecs[i].el, vecs[i].eo, vecs[i].ec, vecs[i].eb);
            end
        end
        reset_n = 1'b1; detected = 1'b0; rpt_ack = 1'b0; clear = 1'b0;

        // Narrow instance: length saturation, MIN_RUN boundary, event_cnt saturation.
        cyc2(0, 1, 0, 0);
        cyc2(0, 1, 0, 0);
        check2("n_reset", 0, 0, 0, 0, 0);
        cyc2(1, 1, 0, 0);
        check2("n_rel_busy", 0, 0, 0, 0, 1);
        for (int i = 0; i < 19; i++) cyc2(1, 1, 0, 0);
        check2("n_long_run", 0, 0, 0, 0, 1);
        cyc2(1, 0, 0, 0);
        check2("n_len_sat", 1, 15, 0, 1, 0);
        cyc2(1, 0, 1, 0);
        check2("n_ack", 0, 15, 0, 1, 0);

        cyc2(1, 1, 0, 0);
        cyc2(1, 1, 0, 0);
        cyc2(1, 0, 0, 0);
        check2("n_short_run", 0, 15, 0, 1, 0);

        for (int i = 0; i < 3; i++) cyc2(1, 1, 0, 0);
        cyc2(1, 0, 0, 0);
        check2("n_min_run", 1, 3, 0, 2, 0);
        cyc2(1, 0, 1, 0);
        check2("n_min_ack", 0, 3, 0, 2, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) cyc2(1, 1, 0, 0);
            cyc2(1, 0, 0, 0);
            check2("n_cnt_sat", 1, 3, 0, 3, 0);
            cyc2(1, 0, 1, 0);
        end
        check2("n_final", 0, 3, 0, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
